sram_host_ctrl: RTL
===================

Name: sram_host_ctrl

Overview:
- Initiator-side controller for the 2 x 1024-word SRAM macro wrapper (2048 x 32 bits, 11-bit word address, active-low write enable, 4-bit byte mask).
- Converts a valid/ready request and response handshake from the bus side into single-cycle SRAM port accesses.
- Handles the macro's one-cycle read latency and response back-pressure, and flags illegal addresses without touching the array.
- Sits between the core/bus fabric and the SRAM wrapper, one instance per SRAM.

Parameters:
- SRAM_AW, 11, SRAM word-address width; 2^SRAM_AW words.
- ADDR_W, 32, request byte-address width.

Ports:
- clk_i  in  1  clock; also drives the SRAM clock.
- rst_ni  in  1  synchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid && ready.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_W  byte address.
- req_be_i  in  4  byte enables (writes only).
- req_wdata_i  in  32  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid && ready.
- rsp_rdata_o  out  32  read data; 0 for writes and errors.
- rsp_err_o  out  1  1 = misaligned or out-of-range request.
- sram_web_o  out  1  SRAM write enable, active low.
- sram_wmask_o  out  4  SRAM byte write mask.
- sram_addr_o  out  SRAM_AW  SRAM word address.
- sram_din_o  out  32  SRAM write data.
- sram_dout_i  in  32  SRAM read data.

Behaviour:
- Reset (rst_ni = 0 at a clk_i edge): state = IDLE, rsp_valid_o = 0, rsp_err_o = 0, rdata register = 0, sram_addr register = 0. Any pending or in-flight response is dropped.
- Address decode:
  - word = req_addr_i[SRAM_AW+1:2].
  - err = (req_addr_i[1:0] != 0) | (req_addr_i[ADDR_W-1:SRAM_AW+2] != 0).
- States:
  - IDLE: no response outstanding.
  - DATA: SRAM data phase, the cycle after accept.
  - HOLD: response stalled by back-pressure.
- req_ready_o = (state == IDLE) | (state == DATA & rsp_ready_i) | (state == HOLD & rsp_ready_i).
- Accept cycle (valid && ready), SRAM pins driven combinationally:
  - sram_addr_o = word.
  - sram_web_o = ~(req_we_i & ~err).
  - sram_wmask_o = req_be_i if write and no err, else 0.
  - sram_din_o = req_wdata_i.
  - The SRAM samples these at the closing edge. The address register loads word, and we/err flags are registered. Next state = DATA.
- Non-accept cycles: sram_web_o = 1, sram_wmask_o = 0, sram_din_o = 0, sram_addr_o = registered last address. A read therefore occurs, but it is harmless. No write may ever occur outside an accept cycle.
- DATA state:
  - rsp_valid_o = 1 and rsp_err_o = registered err.
  - rsp_rdata_o = sram_dout_i for a non-error read, else 0 (passed through combinationally).
  - If rsp_ready_i: the response completes. Next state = DATA if a new request is accepted in the same cycle, else IDLE.
  - If not rsp_ready_i: capture rsp_rdata_o and err into registers; next state = HOLD.
- HOLD state:
  - rsp_valid_o = 1; rsp_rdata_o and rsp_err_o come from registers and stay stable.
  - On rsp_ready_i: next state = DATA if a new request is accepted, else IDLE.
- Latency and throughput:
  - Read accepted in cycle N produces rsp_valid_o in cycle N+1.
  - Sustained throughput is one request per cycle when rsp_ready_i is held high.
- Writes and errors complete on the same N+1 timing with rdata = 0.
- Error requests never assert sram_web_o low and never alter array contents.
- At most one response is outstanding. rsp_valid_o stays high with stable data until consumed.

Test Plan:
1. Reset, then write 0xDEADBEEF to byte addr 0x0000_0010 with be = 0xF, then read it back with rsp_ready_i = 1.
   - Write cycle: sram_addr_o = 4, sram_web_o = 0.
   - Read: rsp_valid_o one cycle after accept, rsp_rdata_o = 0xDEADBEEF, rsp_err_o = 0.
2. Write 0x11223344 to addr 0x1FFC (word 2047, upper bank), then write 0xAABBCCDD there with be = 0x3, then read.
   - rdata = 0x1122CCDD.
   - Read of 0x0FFC returns its independently written value, confirming bank split at word 1024.
3. Back-to-back reads of addrs 0x0, 0x4, 0x8 with rsp_ready_i = 1.
   - req_ready_o stays high.
   - Responses return in consecutive cycles, in order, with correct data.
4. Read 0x8 with rsp_ready_i = 0 for 3 cycles.
   - State HOLD; rsp_valid_o = 1, rsp_rdata_o stable and correct, req_ready_o = 0.
   - After rsp_ready_i = 1, one cycle later rsp_valid_o = 0.
5. Write to 0x0000_2000 (out of range) and to 0x0000_0006 (misaligned).
   - rsp_err_o = 1, rdata = 0, sram_web_o stays 1 throughout.
   - Subsequent reads of words 0 and 1 show unchanged contents.
6. Issue a read, then drive rst_ni = 0 in the DATA cycle.
   - After that edge: rsp_valid_o = 0, req_ready_o = 1, no stale response appears.
   - The next read completes normally.

Source files
------------

// File: rtl/sram_host_ctrl.sv
// rtl/sram_host_ctrl.sv - valid/ready host controller for a 2048 x 32 single-port SRAM
module sram_host_ctrl #(
   parameter int SRAM_AW = 11,
   parameter int ADDR_W  = 32
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic               req_we_i,
   input  logic [ADDR_W-1:0]  req_addr_i,
   input  logic [3:0]         req_be_i,
   input  logic [31:0]        req_wdata_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [31:0]        rsp_rdata_o,
   output logic               rsp_err_o,
   output logic               sram_web_o,
   output logic [3:0]         sram_wmask_o,
   output logic [SRAM_AW-1:0] sram_addr_o,
   output logic [31:0]        sram_din_o,
   input  logic [31:0]        sram_dout_i
);

   // DATA: the SRAM data phase following an accept; HOLD: response stalled by back-pressure
   typedef enum logic [1:0] {IDLE, DATA, HOLD} state_e;

   state_e               state_q, state_d;
   logic [SRAM_AW-1:0]   addr_q, addr_d;
   logic                 we_q, we_d;
   logic                 err_q, err_d;
   logic [31:0]          rdata_q, rdata_d;
   logic                 herr_q, herr_d;

   logic [SRAM_AW-1:0]   word;
   logic                 addr_err;
   logic                 accept;
   logic                 do_write;
   logic [31:0]          data_rdata;

   assign word     = req_addr_i[SRAM_AW+1:2];
   assign addr_err = (req_addr_i[1:0] != 2'b00) | (req_addr_i[ADDR_W-1:SRAM_AW+2] != '0);

   // A new request fits whenever the outstanding response (if any) is leaving this cycle
   assign req_ready_o = (state_q == IDLE)
                      | ((state_q == DATA) & rsp_ready_i)
                      | ((state_q == HOLD) & rsp_ready_i);
   assign accept      = req_valid_i & req_ready_o;
   assign do_write    = accept & req_we_i & ~addr_err;

   // Pins are only live in the accept cycle; otherwise a harmless read of the last address
   assign sram_addr_o  = accept ? word : addr_q;
   assign sram_web_o   = ~do_write;
   assign sram_wmask_o = do_write ? req_be_i : 4'h0;
   assign sram_din_o   = accept ? req_wdata_i : 32'h0;

   // Writes and errors return zero data; reads pass the macro output straight through
   assign data_rdata = (~we_q & ~err_q) ? sram_dout_i : 32'h0;

   // Response outputs: live data in DATA, captured copy in HOLD
   always_comb begin
      rsp_valid_o = 1'b0;
      rsp_err_o   = 1'b0;
      rsp_rdata_o = 32'h0;
      case (state_q)
         DATA: begin
            rsp_valid_o = 1'b1;
            rsp_err_o   = err_q;
            rsp_rdata_o = data_rdata;
         end
         HOLD: begin
            rsp_valid_o = 1'b1;
            rsp_err_o   = herr_q;
            rsp_rdata_o = rdata_q;
         end
         default: ;
      endcase
   end

   // Next-state logic: latch request attributes on accept, capture data on a stall
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      herr_d  = herr_q;
      if (accept) begin
         addr_d = word;
         we_d   = req_we_i;
         err_d  = addr_err;
      end
      case (state_q)
         IDLE: begin
            if (accept) state_d = DATA;
         end
         DATA: begin
            if (rsp_ready_i) begin
               state_d = accept ? DATA : IDLE;
            end else begin
               // The macro output is not guaranteed to persist, so freeze it here
               rdata_d = data_rdata;
               herr_d  = err_q;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (rsp_ready_i) state_d = accept ? DATA : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and request registers; reset drops any outstanding response
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
         herr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         herr_q  <= herr_d;
      end
   end

endmodule
